// File: rtl/ckt_sweep_ctrl.sv
// Exhaustive-sweep controller: walks every input vector of a small
// combinational circuit, waits a settle time, samples its output against a
// truth table and reports pass/fail, error count and first failing vector.
module ckt_sweep_ctrl #(
  parameter int unsigned          N_IN     = 3,
  parameter int unsigned          SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0] EXPECTED = 8'b1001_0110
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            y,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  localparam int unsigned NV   = 2**N_IN;
  localparam int unsigned EW   = N_IN + 1;
  localparam int unsigned CW   = 4;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [CW-1:0]   SET_VAL  = CW'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // With no settle time a vector goes straight to its sample cycle.
  localparam state_t LOAD_ST = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [N_IN-1:0] vec_d, first_fail_d;
  logic [N_IN:0]   err_d;
  logic            fail_valid_d, busy_d, done_d, pass_d;

  // Next-state and next-output logic; abort forces IDLE with cleared results.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    vec_d        = vec;
    err_d        = err_count;
    fail_valid_d = fail_valid;
    first_fail_d = first_fail;

    if (abort) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      vec_d        = '0;
      err_d        = '0;
      fail_valid_d = 1'b0;
      first_fail_d = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d      = LOAD_ST;
            cnt_d        = SET_VAL;
            vec_d        = '0;
            err_d        = '0;
            fail_valid_d = 1'b0;
            first_fail_d = '0;
          end
        end
        ST_WAIT: begin
          cnt_d = cnt - CW'(1);
          if (cnt <= CW'(1)) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (y != EXPECTED[vec]) begin
            err_d = err_count + EW'(1);
            if (!fail_valid) begin
              fail_valid_d = 1'b1;
              first_fail_d = vec;
            end
          end
          if (vec == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec + N_IN'(1);
            cnt_d   = SET_VAL;
            state_d = LOAD_ST;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      vec        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      vec        <= vec_d;
      err_count  <= err_d;
      fail_valid <= fail_valid_d;
      first_fail <= first_fail_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

endmodule
